// File: rtl/ebr_fifo_pkg.sv
// Shared constants and geometry helpers for FIFOs built on one 4 Kbit iCE40UP EBR.
package ebr_fifo_pkg;

    localparam int EBR_BITS = 4096;
    localparam int RAM_AW   = 11;
    localparam int RAM_DW   = 16;

    function automatic int ebr_depth(input int width);
        return EBR_BITS / width;
    endfunction

    function automatic int ebr_aw(input int width);
        return $clog2(EBR_BITS / width);
    endfunction

endpackage

// File: rtl/ebr_fifo_outbuf.sv
// Two-entry skid FIFO that catches EBR read returns; push lands at the edge, head visible next cycle.
// Never sees a push while full: the issue logic keeps occupancy plus in-flight reads at two or less.
module ebr_fifo_outbuf #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [1:0]            ob_cnt
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            cnt_q, cnt_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = push_data;
                else               tail_d = push_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Count unchanged; the new word lands behind whatever survives the pop.
                if (cnt_q == 2'd1) begin
                    head_d = push_data;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data;
                end
            end
            default: ;
        endcase
        if (flush) cnt_d = 2'd0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head_data = head_q;
    assign ob_cnt    = cnt_q;

endmodule

// File: rtl/ebr_fifo_ctrl.sv
// Valid/ready FIFO around one RAM40_4K: 3-edge fall-through, 1 word/clk sustained each way.
// wr_ready drops only when the EBR itself is full; rd_data holds while rd_valid && !rd_ready.
module ebr_fifo_ctrl
    import ebr_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    localparam int ADDR_WIDTH = ebr_aw(DATA_WIDTH),
    localparam int DEPTH      = ebr_depth(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  ram_we,
    output logic [10:0]           ram_waddr,
    output logic [15:0]           ram_wdata,
    output logic [15:0]           ram_mask,
    output logic                  ram_re,
    output logic [10:0]           ram_raddr,
    input  logic [15:0]           ram_rdata
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int LVL_W = ADDR_WIDTH + 2;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0]      ram_cnt_q, ram_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            ob_cnt;
    logic                  wr_fire, rd_issue, pop;
    logic                  rdata_unused;

    assign rdata_unused = ^ram_rdata;

    always_comb begin
        wr_ready = resetn && (ram_cnt_q != DEPTH_C);
        wr_fire  = wr_valid && wr_ready;
        rd_valid = (ob_cnt != 2'd0);
        pop      = rd_valid && rd_ready;
        // Written as a sum comparison so the subtraction of pop cannot underflow.
        rd_issue = resetn && (ram_cnt_q != '0) &&
                   (({1'b0, ob_cnt} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));

        ram_we    = wr_fire;
        ram_re    = rd_issue;
        ram_mask  = 16'h0000;
        ram_waddr = '0;
        ram_waddr[ADDR_WIDTH-1:0] = wptr_q;
        ram_raddr = '0;
        ram_raddr[ADDR_WIDTH-1:0] = rptr_q;
        ram_wdata = '0;
        ram_wdata[DATA_WIDTH-1:0] = wr_data;

        level = LVL_W'(ram_cnt_q) + LVL_W'(inflight_q) + LVL_W'(ob_cnt);
    end

    always_comb begin
        wptr_d     = wr_fire  ? wptr_q + ADDR_WIDTH'(1) : wptr_q;
        rptr_d     = rd_issue ? rptr_q + ADDR_WIDTH'(1) : rptr_q;
        inflight_d = rd_issue;
        case ({wr_fire, rd_issue})
            2'b10:   ram_cnt_d = ram_cnt_q + CNT_W'(1);
            2'b01:   ram_cnt_d = ram_cnt_q - CNT_W'(1);
            default: ram_cnt_d = ram_cnt_q;
        endcase
        if (flush) begin
            wptr_d     = '0;
            rptr_d     = '0;
            ram_cnt_d  = '0;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    ebr_fifo_outbuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_outbuf (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .push      (inflight_q),
        .push_data (ram_rdata[DATA_WIDTH-1:0]),
        .pop       (pop),
        .head_data (rd_data),
        .ob_cnt    (ob_cnt)
    );

endmodule

// File: tb/tb_ebr_fifo_ctrl.sv
// Randomised scoreboard bench for ebr_fifo_ctrl (8-bit words, 512-deep EBR) with a behavioural EBR.
module tb_ebr_fifo_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 512;
    localparam int LW    = 11;

    logic          clk;
    logic          resetn;
    logic          flush;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic [LW-1:0] level;
    logic          ram_we;
    logic [10:0]   ram_waddr;
    logic [15:0]   ram_wdata;
    logic [15:0]   ram_mask;
    logic          ram_re;
    logic [10:0]   ram_raddr;
    logic [15:0]   ram_rdata;

    ebr_fifo_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .level     (level),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_mask  (ram_mask),
        .ram_re    (ram_re),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM40_4K: synchronous write, registered read.
    logic [15:0] mem [0:2047];
    initial ram_rdata = 16'h0;
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    bit mon_en = 1'b0;
    int wcount = 0;
    int pops_seen = 0;
    bit wr_hs, flush_s, rst_s, last_rd_valid;
    logic [DW-1:0] wr_data_s;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: level, wr_ready bounds, stall stability and output order.
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    always @(negedge clk) begin
        if (mon_en) begin
            check(level == LW'(exp_q.size()), "level", level, exp_q.size());
            if (resetn && exp_q.size() < DEPTH)
                check(wr_ready == 1'b1, "wr_ready_open", wr_ready, 1);
            if (exp_q.size() == DEPTH + 2)
                check(wr_ready == 1'b0, "wr_ready_full", wr_ready, 0);
            if (prev_stall)
                check(rd_valid && rd_data == prev_data, "stall_stable", rd_data, prev_data);
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "pop_on_empty", rd_data, 0);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    check(rd_data == e, "rd_data", rd_data, e);
                end
                pops_seen++;
            end
        end
        prev_stall = rd_valid && !rd_ready && !flush && resetn;
        prev_data  = rd_data;
    end

    // One clock of stimulus: sample at negedge, update the model at the edge, drive after it.
    task automatic cycle();
        @(negedge clk);
        wr_hs         = wr_valid && wr_ready;
        wr_data_s     = wr_data;
        flush_s       = flush;
        rst_s         = !resetn;
        last_rd_valid = rd_valid;
        if (wr_hs) begin
            check(ram_we == 1'b1, "ram_we", ram_we, 1);
            check(ram_waddr == 11'(wcount % DEPTH), "ram_waddr", ram_waddr, wcount % DEPTH);
            check(ram_wdata == {8'h00, wr_data}, "ram_wdata", ram_wdata, wr_data);
            check(ram_mask == 16'h0, "ram_mask", ram_mask, 0);
        end
        if (ram_we && ram_re)
            check(ram_waddr != ram_raddr, "addr_collision", ram_raddr, ram_waddr);
        @(posedge clk);
        if (flush_s || rst_s) begin
            exp_q.delete();
            wcount = 0;
        end else if (wr_hs) begin
            exp_q.push_back(wr_data_s);
            wcount++;
        end
        #1;
    endtask

    task automatic drain(input string name);
        int t;
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        t = 0;
        while (level != 0 && t < 2000) begin
            cycle();
            t++;
        end
        check(level == 0 && exp_q.size() == 0, name, level, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n_acc, gaps, p0;
        bit seen, started;

        resetn = 1'b0; flush = 1'b0; wr_valid = 1'b1; wr_data = 8'h11; rd_ready = 1'b1;
        repeat (3) cycle();
        @(negedge clk);
        check(rd_valid == 1'b0, "rst_rd_valid", rd_valid, 0);
        check(level == 0, "rst_level", level, 0);
        check(ram_we == 1'b0, "rst_ram_we", ram_we, 0);
        check(ram_re == 1'b0, "rst_ram_re", ram_re, 0);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        resetn = 1'b1;
        mon_en = 1'b1;
        cycle();
        check(wr_ready == 1'b1, "post_rst_wr_ready", wr_ready, 1);

        // Single word fall-through latency.
        wr_data = 8'hA5; wr_valid = 1'b1;
        cycle();
        check(wr_hs == 1'b1, "t1_accept", wr_hs, 1);
        wr_valid = 1'b0;
        k = 0; seen = 1'b0;
        while (!seen && k < 10) begin
            cycle();
            k++;
            seen = last_rd_valid;
        end
        check(k == 3, "t1_latency", k, 3);
        repeat (3) cycle();
        check(pops_seen == 1 && level == 0, "t1_single", pops_seen, 1);

        // Fill to full with no reads: EBR plus two buffered words.
        rd_ready = 1'b0; n_acc = 0;
        for (int i = 0; i < DEPTH + 10; i++) begin
            wr_valid = 1'b1;
            wr_data  = DW'(n_acc);
            cycle();
            if (wr_hs) n_acc++;
        end
        check(n_acc == DEPTH + 2, "t2_accepted", n_acc, DEPTH + 2);
        check(wr_ready == 1'b0, "t2_wr_ready", wr_ready, 0);
        check(level == LW'(DEPTH + 2), "t2_level", level, DEPTH + 2);
        drain("t2_drain");

        // Full-rate streaming, no output bubbles once started.
        wr_valid = 1'b1; rd_ready = 1'b1; gaps = 0; started = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            wr_data = DW'(i);
            cycle();
            if (last_rd_valid) started = 1'b1;
            else if (started) gaps++;
        end
        check(gaps == 0, "t3_gaps", gaps, 0);
        drain("t3_drain");

        // Random traffic with backpressure, occasional flush and one mid-stream reset.
        for (int i = 0; i < 3000; i++) begin
            wr_valid = ($urandom % 100) < 70;
            wr_data  = DW'($urandom);
            rd_ready = ($urandom % 100) < 30;
            flush    = ($urandom % 250) == 0;
            resetn   = (i != 1500);
            cycle();
        end
        flush = 1'b0; resetn = 1'b1;
        drain("t5_drain");

        // Flush with a read in flight, then a lone word.
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = DW'(8'h70 + i);
            cycle();
        end
        wr_valid = 1'b0; flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();
        check(last_rd_valid == 1'b0, "t6_rd_valid", last_rd_valid, 0);
        check(level == 0, "t6_level", level, 0);
        p0 = pops_seen;
        wr_data = 8'h3C; wr_valid = 1'b1;
        cycle();
        wr_valid = 1'b0; rd_ready = 1'b1;
        repeat (8) cycle();
        check(pops_seen - p0 == 1, "t6_single_out", pops_seen - p0, 1);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
